// File: rtl/snowflake_pkg.sv
// Shared constants and types for the snowflake debug master: frame opcodes,
// response codes and the frame-handling state enum.
package snowflake_pkg;

  localparam logic [7:0] DBG_WRITE = 8'h01;
  localparam logic [7:0] DBG_READ  = 8'h02;
  localparam logic [7:0] DBG_OK    = 8'hAA;
  localparam logic [7:0] DBG_ERR   = 8'hEE;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
    REQ,
    RESP
  } dbg_state_e;

endpackage

// File: rtl/snowflake_debug_master.sv
// Byte-stream driven bus initiator: parses write/read command frames, issues one
// 32-bit bus request per frame and streams the response bytes back out.
module snowflake_debug_master
  import snowflake_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rstz,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wr_data,
  output logic [3:0]  bus_wr_mask,
  output logic        bus_wr_en,
  output logic        bus_req,
  input  logic        bus_ack,
  input  logic [31:0] bus_rd_data,
  output logic        busy
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  dbg_state_e    state, state_next;
  logic [1:0]    byte_cnt;
  logic [TW-1:0] tmo_cnt;
  logic [31:0]   resp;
  logic [2:0]    resp_left;
  logic          rx_fire, tx_fire, tmo_hit;

  assign rx_fire = rx_valid & rx_ready;
  assign tx_fire = tx_valid & tx_ready;
  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT - 1));

  assign bus_req     = (state == REQ);
  assign tx_valid    = (state == RESP);
  assign tx_data     = resp[7:0];
  assign busy        = (state != IDLE);
  assign bus_wr_mask = 4'hF;

  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) state <= IDLE;
    else       state <= state_next;
  end

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (rx_fire) state_next = (rx_data == DBG_WRITE || rx_data == DBG_READ) ? ADDR : RESP;
      ADDR:  if (rx_fire && byte_cnt == 2'd3) state_next = bus_wr_en ? WDATA : REQ;
      WDATA: if (rx_fire && byte_cnt == 2'd3) state_next = REQ;
      REQ:   if (bus_ack || tmo_hit) state_next = RESP;
      RESP:  if (tx_fire && resp_left == 3'd1) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      rx_ready    <= 1'b0;
      byte_cnt    <= '0;
      tmo_cnt     <= '0;
      bus_addr    <= '0;
      bus_wr_data <= '0;
      bus_wr_en   <= 1'b0;
      resp        <= '0;
      resp_left   <= '0;
    end else begin
      // Registered from the next state so it stays low through reset and REQ/RESP.
      rx_ready <= (state_next == IDLE) || (state_next == ADDR) || (state_next == WDATA);
      unique case (state)
        IDLE: if (rx_fire) begin
          byte_cnt <= '0;
          if (rx_data == DBG_WRITE || rx_data == DBG_READ) begin
            bus_wr_en <= (rx_data == DBG_WRITE);
          end else begin
            resp      <= {24'h0, DBG_ERR};
            resp_left <= 3'd1;
          end
        end
        ADDR: if (rx_fire) begin
          // LSB-first shift; the low two bits are cleared so the final address is word aligned.
          bus_addr <= {rx_data, bus_addr[31:10], 2'b00};
          byte_cnt <= byte_cnt + 2'd1;
        end
        WDATA: if (rx_fire) begin
          bus_wr_data <= {rx_data, bus_wr_data[31:8]};
          byte_cnt    <= byte_cnt + 2'd1;
        end
        REQ: begin
          if (bus_ack) begin
            tmo_cnt <= '0;
            if (bus_wr_en) begin
              resp      <= {24'h0, DBG_OK};
              resp_left <= 3'd1;
            end else begin
              resp      <= bus_rd_data;
              resp_left <= 3'd4;
            end
          end else if (tmo_hit) begin
            tmo_cnt   <= '0;
            resp      <= {24'h0, DBG_ERR};
            resp_left <= 3'd1;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        RESP: if (tx_fire) begin
          // Shifting in zeros leaves tx_data at 0 once the response is drained.
          resp      <= {8'h0, resp[31:8]};
          resp_left <= resp_left - 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snowflake_debug_master.sv
// Scoreboard bench for snowflake_debug_master: frames are issued from a word-level
// model with a small memory; bus and tx monitors pop and compare independently.
module tb_snowflake_debug_master;
  import snowflake_pkg::*;

  localparam int TIMEOUT = 16;

  logic        clk, rstz;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [31:0] bus_addr, bus_wr_data, bus_rd_data;
  logic [3:0]  bus_wr_mask;
  logic        bus_wr_en, bus_req, bus_ack, busy;

  snowflake_debug_master #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rstz(rstz),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .bus_addr(bus_addr), .bus_wr_data(bus_wr_data), .bus_wr_mask(bus_wr_mask),
    .bus_wr_en(bus_wr_en), .bus_req(bus_req), .bus_ack(bus_ack),
    .bus_rd_data(bus_rd_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] rd;
    int          ack_delay;  // -1: never acknowledge
    bit          abort;      // request is cut short by reset
  } bus_item_t;

  bus_item_t   exp_bus[$];
  logic [7:0]  exp_tx[$];
  logic [31:0] mem [logic [31:0]];
  int          tx_mode;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic report_fail(input string name, input logic [31:0] act);
    n_tests++;
    n_fail++;
    $display("FAIL %s: observed 0x%0h where the model expected none (t=%0t)", name, act, $time);
  endtask

  // tx sink: always ready, toggling, or random
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tx_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = ~tx_ready;
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // tx monitor
  initial begin
    logic [7:0] held;
    bit         holding;
    holding = 0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!rstz) begin
        holding = 0;
      end else begin
        if (holding && tx_valid) check("tx_hold_stable", 32'(tx_data), 32'(held));
        if (tx_valid && tx_ready) begin
          if (exp_tx.size() == 0) report_fail("tx_unexpected_byte", 32'(tx_data));
          else check("tx_byte", 32'(tx_data), 32'(exp_tx.pop_front()));
          holding = 0;
        end else if (tx_valid) begin
          held    = tx_data;
          holding = 1;
        end else begin
          holding = 0;
        end
      end
    end
  end

  // bus responder and monitor
  initial begin
    bus_ack     = 1'b0;
    bus_rd_data = '0;
    forever begin
      @(negedge clk);
      if (rstz && bus_req) begin
        bus_item_t it;
        int        cyc;
        bit        stable;
        if (exp_bus.size() == 0) begin
          report_fail("bus_unexpected_req", bus_addr);
          cyc = 0;
          while (bus_req && cyc < 100) begin @(negedge clk); cyc++; end
        end else begin
          it = exp_bus.pop_front();
          check("bus_addr", bus_addr, it.addr);
          check("bus_wr_en", 32'(bus_wr_en), 32'(it.wr));
          if (it.wr) check("bus_wr_data", bus_wr_data, it.wdata);
          check("bus_wr_mask", 32'(bus_wr_mask), 32'hF);
          cyc    = 0;
          stable = 1;
          while (bus_req && cyc < 100) begin
            if (bus_addr !== it.addr || bus_wr_en !== it.wr || rx_ready !== 1'b0 ||
                (it.wr && bus_wr_data !== it.wdata)) stable = 0;
            if (it.ack_delay == cyc) begin
              bus_ack     = 1'b1;
              bus_rd_data = it.rd;
            end else begin
              bus_ack     = 1'b0;
              bus_rd_data = $urandom;
            end
            @(negedge clk);
            cyc++;
          end
          bus_ack = 1'b0;
          check("bus_req_stable", 32'(stable), 32'd1);
          if (!it.abort) begin
            check("bus_req_cycles", 32'(cyc), 32'(it.ack_delay >= 0 ? it.ack_delay + 1 : TIMEOUT));
            if (it.ack_delay < 0) begin
              // late acknowledge after the timeout must be ignored
              bus_ack     = 1'b1;
              bus_rd_data = $urandom;
              @(negedge clk);
              bus_ack = 1'b0;
            end
          end
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n        = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 300) begin @(negedge clk); n++; end
    if (!rx_ready) report_fail("rx_ready_wait_expired", 32'(b));
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input int delay);
    bus_item_t it;
    it = '{addr: addr & ~32'h3, wdata: data, wr: 1'b1, rd: 32'h0, ack_delay: delay, abort: 1'b0};
    exp_bus.push_back(it);
    if (delay >= 0) begin
      exp_tx.push_back(DBG_OK);
      mem[addr & ~32'h3] = data;
    end else begin
      exp_tx.push_back(DBG_ERR);
    end
    send_byte(DBG_WRITE);
    send_word(addr);
    send_word(data);
  endtask

  task automatic do_read(input logic [31:0] addr, input int delay);
    bus_item_t   it;
    logic [31:0] a, rd;
    a  = addr & ~32'h3;
    rd = mem.exists(a) ? mem[a] : $urandom;
    it = '{addr: a, wdata: 32'h0, wr: 1'b0, rd: rd, ack_delay: delay, abort: 1'b0};
    exp_bus.push_back(it);
    if (delay >= 0) for (int i = 0; i < 4; i++) exp_tx.push_back(rd[8*i +: 8]);
    else exp_tx.push_back(DBG_ERR);
    send_byte(DBG_READ);
    send_word(addr);
  endtask

  task automatic do_bad(input logic [7:0] op);
    exp_tx.push_back(DBG_ERR);
    send_byte(op);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rstz     = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    tx_mode  = 0;
    #2;
    check("rst_rx_ready", 32'(rx_ready), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'd0);
    check("rst_bus_req", 32'(bus_req), 32'd0);
    check("rst_bus_wr_en", 32'(bus_wr_en), 32'd0);
    check("rst_bus_addr", bus_addr, 32'd0);
    check("rst_bus_wr_data", bus_wr_data, 32'd0);
    check("rst_bus_wr_mask", 32'(bus_wr_mask), 32'hF);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rstz = 1'b1;
    @(negedge clk);
    check("idle_rx_ready", 32'(rx_ready), 32'd1);

    // directed frames
    do_write(32'h0000_0010, 32'hDEAD_BEEF, 3);
    tx_mode = 1;
    mem[32'h4] = 32'h1234_5678;
    do_read(32'h0000_0004, 0);
    tx_mode = 0;
    do_bad(8'h7F);
    do_write(32'h0000_0020, 32'hCAFE_F00D, 1);
    do_write(32'h0000_0030, 32'h0BAD_0BAD, -1);
    do_read(32'h0000_0013, 2);

    // reset while the request is outstanding
    exp_bus.push_back('{addr: 32'h40, wdata: 32'h0, wr: 1'b0, rd: 32'h0, ack_delay: -1, abort: 1'b1});
    send_byte(DBG_READ);
    send_word(32'h0000_0040);
    n = 0;
    while (!bus_req && n < 100) begin @(negedge clk); n++; end
    if (!bus_req) report_fail("abort_req_wait_expired", 32'(n));
    repeat (3) @(negedge clk);
    rstz = 1'b0;
    #1;
    check("abort_bus_req", 32'(bus_req), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_rx_ready", 32'(rx_ready), 32'd0);
    check("abort_tx_valid", 32'(tx_valid), 32'd0);
    check("abort_bus_addr", bus_addr, 32'd0);
    @(negedge clk);
    rstz = 1'b1;
    @(negedge clk);
    do_read(32'h0000_0044, 2);

    // randomized traffic
    for (int i = 0; i < 40; i++) begin
      int          kind, delay;
      logic [31:0] addr;
      logic [7:0]  op;
      tx_mode = $urandom_range(0, 2);
      kind    = $urandom_range(0, 4);
      addr    = $urandom & 32'h0000_003F;
      delay   = $urandom_range(0, 7);
      if (delay == 7) delay = -1;
      if (kind <= 1) do_write(addr, $urandom, delay);
      else if (kind <= 3) do_read(addr, delay);
      else begin
        op = 8'($urandom);
        if (op == DBG_WRITE || op == DBG_READ) op = 8'h00;
        do_bad(op);
      end
    end

    n = 0;
    while ((exp_tx.size() != 0 || exp_bus.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("drain_tx_queue", 32'(exp_tx.size()), 32'd0);
    check("drain_bus_queue", 32'(exp_bus.size()), 32'd0);
    check("final_busy", 32'(busy), 32'd0);
    check("final_rx_ready", 32'(rx_ready), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snowflake_debug_master.md
# snowflake_debug_master

Byte-stream-driven bus initiator for the snowflake platform. It sits beside the Kronos core as a second initiator on the system bus data port (req/ack). It turns a command byte stream, normally from a UART receiver, into 32-bit word reads and writes of memory or system registers. Response bytes go back on an outbound stream, normally to a UART transmitter, for program loading and register poking without the core.

## Interface
Parameters:
- `TIMEOUT`, default 1024: cycles to wait for `ack` before aborting a bus request; minimum 2.

Ports:
- `clk`  in  1  system clock
- `rstz`  in  1  asynchronous, active-low reset
- `rx_data`  in  8  inbound command byte
- `rx_valid`  in  1  `rx_data` valid
- `rx_ready`  out  1  block accepts a byte; transfer when `rx_valid & rx_ready`
- `tx_data`  out  8  outbound response byte
- `tx_valid`  out  1  `tx_data` valid; held until accepted
- `tx_ready`  in  1  sink accepts byte; transfer when `tx_valid & tx_ready`
- `bus_addr`  out  32  word address
- `bus_wr_data`  out  32  write data
- `bus_wr_mask`  out  4  byte write mask
- `bus_wr_en`  out  1  1 = write, 0 = read
- `bus_req`  out  1  request, held until `bus_ack` or timeout
- `bus_ack`  in  1  one-cycle acknowledge; `bus_rd_data` valid in the same cycle
- `bus_rd_data`  in  32  read data
- `busy`  out  1  high in any state other than IDLE

## Operation
- Frame formats, multi-byte fields LSB first:
  - Write: `0x01`, A0..A3, D0..D3
  - Read: `0x02`, A0..A3
- Address bits [1:0] are forced to 0. `bus_wr_mask` is always 4'hF.
- States:
  - IDLE: `rx_ready=1`.
    - Byte `0x01` or `0x02`: latch opcode, clear byte counter, go to ADDR.
    - Any other byte: go to RESP with the single byte `0xEE`.
  - ADDR: accept 4 bytes into the address shift register. After the 4th byte, a write goes to WDATA and a read goes to REQ.
  - WDATA: accept 4 bytes into the data register, then go to REQ.
  - REQ: `rx_ready=0`, `bus_req=1`, timeout counter runs.
    - `bus_ack`: drop `bus_req` the next cycle. A read captures `bus_rd_data` and goes to RESP with 4 bytes. A write goes to RESP with `0xAA`.
    - Counter reaches `TIMEOUT-1` with no ack: drop `bus_req`, go to RESP with `0xEE`.
  - RESP: `rx_ready=0`. Present bytes in order and advance one byte per tx transfer. After the last transfer, go to IDLE.
- `rx_ready` is 0 in REQ and RESP. Bytes are never dropped; backpressure is the only flow control.
- `bus_addr`, `bus_wr_data` and `bus_wr_en` are stable for the whole time `bus_req` is high.
- The 2-bit byte counter wraps 3→0 on each field completion.

## Timing
- Reset values: `rx_ready=0` during reset, then 1 in IDLE. `tx_valid=0`, `tx_data=0`, `bus_req=0`, `bus_wr_en=0`, `bus_addr=0`, `bus_wr_data=0`, `bus_wr_mask=4'hF`, `busy=0`. State is IDLE and all counters are 0.
- One byte is accepted per cycle when `rx_valid` is held.
- `bus_req` rises the cycle after the last frame byte is accepted.
- `bus_ack` in cycle N gives `bus_req=0` and `tx_valid=1` in cycle N+1.
- `bus_ack` and the timeout expiring in the same cycle: the ack wins.
- `bus_ack` while `bus_req=0` is ignored.
- `tx_data` must not change while `tx_valid & ~tx_ready`.
- Reset asserted mid-frame or mid-request: all outputs return to their reset values immediately (asynchronous). The partial frame is discarded.
- All state is registered on `posedge clk`. There are no combinational paths from `bus_ack` to `rx_ready` or `tx_*`.

## Structure
- `snowflake_pkg` holds:
  - opcodes `DBG_WRITE=8'h01` and `DBG_READ=8'h02`
  - response codes `DBG_OK=8'hAA` and `DBG_ERR=8'hEE`
  - the state enum (IDLE, ADDR, WDATA, REQ, RESP)
- Single module with no sub-modules. The shift registers and counters are small enough to stay inline.

## Test plan
- Write frame `01 10 00 00 00 EF BE AD DE` → one `bus_req` with `bus_addr=0x10`, `bus_wr_data=0xDEADBEEF`, `bus_wr_en=1`, `bus_wr_mask=F`. Ack after 3 cycles → tx byte `AA`.
- Read frame `02 04 00 00 00`, ack with `bus_rd_data=0x12345678` → tx `78 56 34 12`. With `tx_ready` toggling every other cycle, the bytes stay ordered and stable.
- Unknown opcode `0x7F` → tx `EE`, no `bus_req`, then back to IDLE, and a following valid frame is accepted.
- No ack with `TIMEOUT=16` → `bus_req` high for exactly 16 cycles, then tx `EE`. A late `bus_ack` after that is ignored.
- Address `0x00000013` → `bus_addr=0x10`.
- `rstz` pulsed low while `bus_req=1` → `bus_req` drops at once and `busy=0`. A following read frame completes normally.
